or_mux_rr_arbiter: RTL and testbench
====================================

// Module: or_mux_rr_arbiter
//
// PURPOSE
//  Round-robin arbiter and output stage for the NUMBER_INPUT x BIT OR-based selector datapath.
//  - Shares the single BIT-wide output among NUMBER_INPUT requesters using valid/ready handshakes.
//  - Gates each input word with its one-hot grant bit, then OR-reduces all gated words.
//  - Registers the result with a one-entry output buffer that honours backpressure.
//
// PARAMETERS
//  BIT           19   width of each data word and of out
//  NUMBER_INPUT  8    number of requesters (>=2); pointer width = $clog2(NUMBER_INPUT)
//
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 asynchronous active-low reset
//  in_valid   in   NUMBER_INPUT      per-requester valid; bit j qualifies IN[j*BIT +: BIT]
//  IN         in   NUMBER_INPUT*BIT  packed request data; word j = IN[j*BIT +: BIT]
//  in_ready   out  NUMBER_INPUT      combinational; one-hot or zero; beat j accepted when in_valid[j]&in_ready[j]
//  out_valid  out  1                 registered; out holds a valid word
//  out        out  BIT               registered OR-reduced word of the granted requester
//  out_ready  in   1                 downstream accepts out when out_valid&out_ready
//  grant      out  NUMBER_INPUT      registered one-hot source index of current out; zero when !out_valid
//
// BEHAVIOUR
//  - Reset (async, rst_n=0): out=0, out_valid=0, grant=0, pointer ptr=0, lock cleared. in_ready=0 while in reset.
//  - slot_free = !out_valid | out_ready. When !slot_free: in_ready=0, and out/grant/out_valid hold stable.
//  - Arbitration when slot_free: winner g = first j with in_valid[j]=1, searching ptr, ptr+1, ... mod NUMBER_INPUT.
//    - Combinational outputs: in_ready = onehot(g).
//    - Next edge: out <= OR_j(IN[j] & {BIT{onehot(g)[j]}}), out_valid<=1, grant<=onehot(g), ptr <= (g+1) mod N.
//  - slot_free with no in_valid: out_valid<=0, grant<=0, out holds last value, ptr unchanged.
//  - Latency: 1 cycle from acceptance to out_valid. Throughput: 1 beat/cycle while out_ready=1.
//  - Wrap-around: winner N-1 sets ptr=0. ptr always advances one past the winner, never to a fixed value.
//  - Simultaneous pop and push (out_valid&out_ready with a request present): the new beat replaces the popped one in the same edge, with no bubble.
//  - in_valid may drop without being accepted; the arbiter keeps no per-requester state.
//  - X on IN for a non-granted requester must not propagate: IN words are gated before the OR.
//  - Reset mid-operation drops any buffered beat; after release, arbitration restarts at requester 0.
//
// CONFIGURATION
//  OR_ARB_LOCK_EN defined:
//   - Adds input port in_last [NUMBER_INPUT] (burst end marker).
//   - Lock set: an accepted beat with in_last[g]=0 sets lock=1 and lock_id=g.
//   - While locked, only requester lock_id is eligible; all other in_valid bits are ignored.
//   - Lock clear: accepted beat from lock_id with in_last=1.
//   - ptr updates only when the lock clears (ptr=lock_id+1).
//   - Reset clears the lock.
//  OR_ARB_LOCK_EN undefined:
//   - No in_last port and no lock state.
//   - Every beat is arbitrated independently as described above.
//
// TESTING
//  1. Reset: hold rst_n=0 with random IN and in_valid=8'hFF -> out=0, out_valid=0, grant=0, in_ready=0.
//  2. Single requester: in_valid=8'h08, IN word3=19'h12345, out_ready=1 -> in_ready=8'h08; next cycle out=19'h12345, out_valid=1, grant=8'h08.
//  3. All requesters: in_valid=8'hFF for 9 cycles, out_ready=1, word j=j+1 -> grants 0,1,...,7, then 0 (wrap); out=1..8, then 1.
//  4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out/grant stable, in_ready=0; on out_ready=1 the next rotation winner loads the same cycle.
//  5. Pointer: after grant 6, in_valid=8'h84 -> grant 7, then grant 2.
//  6. Lock: with OR_ARB_LOCK_EN, req0 bursts 3 beats (in_last 0,0,1) while req1 is valid -> grants 0,0,0,1.
//     Without the macro -> grants 0,1,0,1.
//  7. Reset mid-stream: assert rst_n=0 while out_valid=1 -> outputs clear asynchronously; after release, first grant is the lowest valid index.

Source files
------------

// File: rtl/or_mux_rr_arbiter.sv
// Round-robin arbiter with an OR-based word selector and a one-entry registered output stage.
// Requesters share one BIT-wide output through valid/ready handshakes. The winner's word is
// gated by its one-hot grant and OR-reduced, so unselected (possibly X) words never leak.
// Optional feature: define OR_ARB_LOCK_EN to add in_last and hold the grant for whole bursts.
module or_mux_rr_arbiter #(
  parameter int unsigned BIT          = 19,
  parameter int unsigned NUMBER_INPUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUMBER_INPUT-1:0]     in_valid,
  input  logic [NUMBER_INPUT*BIT-1:0] IN,
`ifdef OR_ARB_LOCK_EN
  input  logic [NUMBER_INPUT-1:0]     in_last,
`endif
  output logic [NUMBER_INPUT-1:0]     in_ready,
  output logic                        out_valid,
  output logic [BIT-1:0]              out,
  input  logic                        out_ready,
  output logic [NUMBER_INPUT-1:0]     grant
);

  localparam int unsigned PtrW = $clog2(NUMBER_INPUT);

  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic                    out_valid_q, out_valid_d;
  logic [BIT-1:0]          out_q, out_d;
  logic [NUMBER_INPUT-1:0] grant_q, grant_d;

`ifdef OR_ARB_LOCK_EN
  logic                    lock_q, lock_d;
  logic [PtrW-1:0]         lock_id_q, lock_id_d;
`endif

  logic [NUMBER_INPUT-1:0] elig;
  logic                    found;
  logic [PtrW-1:0]         win;
  logic [PtrW-1:0]         idx;
  logic [PtrW-1:0]         ptr_inc;
  logic [NUMBER_INPUT-1:0] grant_oh;
  logic                    slot_free;
  logic [BIT-1:0]          data_or;

  assign slot_free = ~out_valid_q | out_ready;

  // Eligible requesters: everyone, or only the lock holder while a burst is in flight.
  always_comb begin
    elig = in_valid;
`ifdef OR_ARB_LOCK_EN
    if (lock_q) begin
      elig            = '0;
      elig[lock_id_q] = in_valid[lock_id_q];
    end
`endif
  end

  // Rotating priority search starting at ptr_q; the first eligible index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUMBER_INPUT; k++) begin
      idx = PtrW'((32'(ptr_q) + k) % NUMBER_INPUT);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot grant, gated ready, and the gate-then-OR data selector.
  always_comb begin
    grant_oh = '0;
    if (found) grant_oh[win] = 1'b1;
    in_ready = (rst_n && slot_free) ? grant_oh : '0;
    data_or  = '0;
    for (int unsigned j = 0; j < NUMBER_INPUT; j++) begin
      data_or = data_or | (IN[j*BIT +: BIT] & {BIT{grant_oh[j]}});
    end
    ptr_inc = (win == PtrW'(NUMBER_INPUT - 1)) ? '0 : win + PtrW'(1);
  end

  // Next state of the output buffer, pointer and (optionally) burst lock.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
`ifdef OR_ARB_LOCK_EN
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
`endif
    if (slot_free) begin
      if (found) begin
        out_d       = data_or;
        out_valid_d = 1'b1;
        grant_d     = grant_oh;
`ifdef OR_ARB_LOCK_EN
        // A non-last beat opens (or keeps) the lock; the last beat releases it and rotates.
        lock_d    = ~in_last[win];
        lock_id_d = win;
        if (in_last[win]) ptr_d = ptr_inc;
`else
        ptr_d = ptr_inc;
`endif
      end else begin
        // Idle: drop valid and grant, keep the last data word.
        out_valid_d = 1'b0;
        grant_d     = '0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      ptr_q       <= '0;
`ifdef OR_ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
`ifdef OR_ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_or_mux_rr_arbiter.sv
// Self-checking bench for or_mux_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural round-robin model.
module tb_or_mux_rr_arbiter;

  localparam int BIT = 19;
  localparam int NI  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     in_valid;
  logic [NI*BIT-1:0] in_data;
  logic [NI-1:0]     in_ready;
  logic              out_valid;
  logic [BIT-1:0]    out;
  logic              out_ready;
  logic [NI-1:0]     grant;
`ifdef OR_ARB_LOCK_EN
  logic [NI-1:0]     in_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  or_mux_rr_arbiter #(.BIT(BIT), .NUMBER_INPUT(NI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .IN        (in_data),
`ifdef OR_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  // Model state: buffered beat, winner index of that beat, rotation pointer, burst lock.
  typedef struct packed {
    logic           valid;
    logic [BIT-1:0] data;
    logic [NI-1:0]  grant;
    int             ptr;
    logic           lock;
    int             lock_id;
  } mstate_t;

  mstate_t m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input mstate_t s, input logic [NI-1:0] v);
    for (int k = 0; k < NI; k++) begin
      int j;
      j = (s.ptr + k) % NI;
      if (v[j] && (!s.lock || j == s.lock_id)) return j;
    end
    return -1;
  endfunction

  function automatic mstate_t nxt(input mstate_t s);
    mstate_t r;
    int w;
    r = s;
    if (s.valid && !out_ready) return r;
    w = pick(s, in_valid);
    if (w < 0) begin
      r.valid = 1'b0;
      r.grant = '0;
    end else begin
      r.valid = 1'b1;
      r.data  = in_data[w*BIT +: BIT];
      r.grant = NI'(1) << w;
`ifdef OR_ARB_LOCK_EN
      if (!in_last[w]) begin
        r.lock    = 1'b1;
        r.lock_id = w;
      end else begin
        r.lock = 1'b0;
        r.ptr  = (w + 1) % NI;
      end
`else
      r.ptr = (w + 1) % NI;
`endif
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= nxt(m);
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    int w;
    logic [NI-1:0] exp_rdy;
    w = pick(m, in_valid);
    exp_rdy = '0;
    if (rst_n && (!m.valid || out_ready) && w >= 0) exp_rdy = NI'(1) << w;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m.valid));
    chk("grant", 32'(grant), 32'(m.grant));
    chk("out", 32'(out), 32'(m.data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int j = 0; j < NI; j++) in_data[j*BIT +: BIT] = BIT'($urandom);
  endtask

  logic [NI-1:0] exp6 [4];
  logic [NI-1:0] got6 [4];

  initial begin
    rst_n     = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    rand_data();
`ifdef OR_ARB_LOCK_EN
    in_last   = '1;
    exp6[0] = 8'h01; exp6[1] = 8'h01; exp6[2] = 8'h01; exp6[3] = 8'h02;
`else
    exp6[0] = 8'h01; exp6[1] = 8'h02; exp6[2] = 8'h01; exp6[3] = 8'h02;
`endif
    #1 rst_n = 1'b0;

    // Reset held with all requesters valid.
    repeat (3) begin
      step();
      rand_data();
    end
    @(negedge clk);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);

    // Single requester 3.
    step();
    rst_n = 1'b1;
    in_valid = 8'h08;
    in_data[3*BIT +: BIT] = 19'h12345;
    @(negedge clk);
    chk("single_ready", 32'(in_ready), 32'h08);
    step();
    @(negedge clk);
    chk("single_out", 32'(out), 32'h12345);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_grant", 32'(grant), 32'h08);

    // Asynchronous reset while a beat is buffered.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_out", 32'(out), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h0);

    // All requesters valid: rotation from 0 with wrap.
    step();
    rst_n = 1'b1;
    in_valid = '1;
    for (int j = 0; j < NI; j++) in_data[j*BIT +: BIT] = BIT'(j + 1);
    for (int i = 0; i < 9; i++) begin
      step();
      @(negedge clk);
      chk("rot_grant", 32'(grant), 32'(NI'(1) << (i % NI)));
      chk("rot_out", 32'(out), 32'((i % NI) + 1));
    end

    // Backpressure: everything holds, in_ready low.
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("bp_grant", 32'(grant), 32'h01);
      chk("bp_out", 32'(out), 32'h1);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_ready", 32'(in_ready), 32'h0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'h02);
    step();
    in_valid = 8'h40;
    @(negedge clk);
    chk("bp_release_grant", 32'(grant), 32'h02);
    chk("bp_release_out", 32'(out), 32'h2);

    // Pointer advances one past the winner.
    step();
    in_valid = 8'h84;
    @(negedge clk);
    chk("ptr_g6", 32'(grant), 32'h40);
    step();
    @(negedge clk);
    chk("ptr_g7", 32'(grant), 32'h80);
    step();
    in_valid = 8'h03;
`ifdef OR_ARB_LOCK_EN
    in_last = 8'hFE;
`endif
    @(negedge clk);
    chk("ptr_g2", 32'(grant), 32'h04);

    // Requesters 0 and 1 competing; requester 0 sends a 3-beat burst.
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef OR_ARB_LOCK_EN
      in_last = (i == 0) ? 8'hFE : 8'hFF;
`endif
      @(negedge clk);
      got6[i] = grant;
    end
    for (int i = 0; i < 4; i++) chk("burst_grant", 32'(got6[i]), 32'(exp6[i]));

    // Randomized traffic, including occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 499) != 0);
      case ($urandom_range(0, 3))
        0:       in_valid = ($urandom_range(0, 1) != 0) ? (NI'(1) << $urandom_range(0, NI - 1)) : '0;
        1:       in_valid = NI'($urandom);
        2:       in_valid = '1;
        default: in_valid = NI'($urandom) & NI'($urandom);
      endcase
      rand_data();
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef OR_ARB_LOCK_EN
      in_last = NI'($urandom) | NI'($urandom);
`endif
    end
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
